rtl_call_issuer: RTL

Initiator-side bridge for stall-aware RTL library functions such as the 32-bit uint adder. It accepts operand pairs from an upstream valid/ready stream and issues them to a callee over the ivalid/iready/ovalid/oready library handshake. It tracks in-flight calls with a credit counter and buffers returned results in an output FIFO. It sits between the group-count datapath and any library function whose result latency is fixed or variable but in-order.

---
 rtl/rtl_call_pkg.sv | 18 +
 rtl/rtl_call_result_fifo.sv | 68 ++++++
 rtl/rtl_call_issuer.sv | 117 +++++++++++
 3 files changed

// File: rtl/rtl_call_pkg.sv
// Shared definitions for the RTL library call issuer: default data width,
// counter-width helper and the sticky error vector layout.
package rtl_call_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  // Bits needed to index n distinct values (minimum 1).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic spurious;
    logic overflow;
    logic timeout;
  } err_vec_t;

endpackage

// File: rtl/rtl_call_result_fifo.sv
// Result FIFO for the call issuer: DEPTH x DATA_W synchronous FIFO with a
// registered first-word-fall-through head, wrap-bit pointers and occupancy.
module rtl_call_result_fifo
  import rtl_call_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [DATA_W-1:0]               wr_data,
  output logic                            full,
  input  logic                            rd_en,
  output logic                            rd_valid,
  output logic [DATA_W-1:0]               rd_data,
  output logic [cnt_w(DEPTH+1)-1:0]       count
);

  localparam int unsigned AW = cnt_w(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = cnt_w(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [DATA_W-1:0] head_nxt;
  logic              empty, do_wr, do_rd;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = CW'(wr_ptr - rd_ptr);
  assign rd_valid = !empty;
  assign do_wr    = wr_en & !full;
  assign do_rd    = rd_en & !empty;

  // Next head word: the freshly written entry bypasses the array when it
  // becomes the head; an emptied FIFO keeps its last output word.
  always_comb begin
    rd_ptr_nxt = rd_ptr + PW'(do_rd);
    wr_ptr_nxt = wr_ptr + PW'(do_wr);
    head_nxt   = rd_data;
    if (wr_ptr_nxt != rd_ptr_nxt) begin
      if (do_wr && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]))
        head_nxt = wr_data;
      else
        head_nxt = mem[rd_ptr_nxt[AW-1:0]];
    end
  end

  // Storage array write port.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointers and registered head word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      rd_data <= head_nxt;
    end
  end

endmodule

// File: rtl/rtl_call_issuer.sv
// Initiator-side bridge to a stall-aware library function. Operands are
// issued while credits remain; in-order results are queued in a result FIFO.
// Optional watchdog: define RTL_CALL_TIMEOUT_EN to enable err_timeout.
module rtl_call_issuer
  import rtl_call_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_a,
  input  logic [DATA_W-1:0] s_b,
  output logic              f_ivalid,
  input  logic              f_oready,
  output logic [DATA_W-1:0] f_a,
  output logic [DATA_W-1:0] f_b,
  input  logic              f_ovalid,
  output logic              f_iready,
  input  logic [DATA_W-1:0] f_result,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              err_spurious,
  output logic              err_overflow,
  output logic              err_timeout
);

  localparam int unsigned CW = cnt_w(DEPTH + 1);

  logic [CW-1:0] outstanding, fifo_count;
  logic [CW:0]   in_use;
  logic          has_credit, fifo_full, issue, ret;
  logic          spurious_hit, overflow_hit, timeout_hit;
  err_vec_t      err_q;

  assign in_use     = {1'b0, outstanding} + {1'b0, fifo_count};
  assign has_credit = in_use < (CW+1)'(DEPTH);

  assign f_ivalid = s_valid & has_credit & !reset;
  assign s_ready  = f_oready & has_credit & !reset;
  assign f_a      = s_a;
  assign f_b      = s_b;
  assign issue    = f_ivalid & f_oready;

  assign f_iready     = !fifo_full;
  assign spurious_hit = f_ovalid & (outstanding == '0);
  assign overflow_hit = f_ovalid & fifo_full;
  assign ret          = f_ovalid & !fifo_full & (outstanding != '0);

  rtl_call_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (ret),
    .wr_data  (f_result),
    .full     (fifo_full),
    .rd_en    (m_ready),
    .rd_valid (m_valid),
    .rd_data  (m_data),
    .count    (fifo_count)
  );

  // In-flight call count: net effect of issue and accepted return.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({issue, ret})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef RTL_CALL_TIMEOUT_EN
  localparam int unsigned TW = cnt_w(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;

  assign timeout_hit = (outstanding != '0) && !ret && (wd_cnt == TW'(TIMEOUT - 1));

  // Watchdog: counts idle cycles while calls are pending, saturating at TIMEOUT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if ((outstanding == '0) || ret) begin
      wd_cnt <= '0;
    end else if (wd_cnt != TW'(TIMEOUT)) begin
      wd_cnt <= wd_cnt + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q.spurious <= err_q.spurious | spurious_hit;
      err_q.overflow <= err_q.overflow | overflow_hit;
      err_q.timeout  <= err_q.timeout  | timeout_hit;
    end
  end

  assign err_spurious = err_q.spurious;
  assign err_overflow = err_q.overflow;
  assign err_timeout  = err_q.timeout;

endmodule
